// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types and constants for the full-speed USB transceiver.
// Used by the transmit path; the line-state enum also names the NRZI level.
package usb_utmi_pkg;

  typedef enum logic [1:0] {DJ, DK, SE0} utmi_line_state_t;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} usb_tx_state_t;

  localparam logic [7:0] USB_SYNC_BYTE   = 8'h80;
  localparam int         USB_STUFF_LIMIT = 6;

  // NRZI: a 0 flips the line level, a 1 keeps it.
  function automatic utmi_line_state_t nrzi_next(input utmi_line_state_t level,
                                                 input logic bit_val);
    if (bit_val) return level;
    return (level == DK) ? DJ : DK;
  endfunction

endpackage

// File: rtl/usb_utm_tx.sv
// Full-speed UTM transmit path: UTMI byte handshake in, SYNC + stuffed
// NRZI bit stream + EOP out on the single-ended frontend pins.
module usb_utm_tx
  import usb_utmi_pkg::*;
#(
  parameter int CLK_PER_BIT  = 4,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       dp_tx,
  output logic       dn_tx,
  output logic       tx_oen
);

  localparam int            TW          = $clog2(CLK_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    STUFF_LIMIT = 3'(USB_STUFF_LIMIT);
  localparam logic [2:0]    EOP_LAST    = 3'(EOP_SE0_BITS - 1);

  usb_tx_state_t    state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [2:0]       ones_q, ones_d;
  logic [7:0]       shift_q, shift_d;
  utmi_line_state_t level_q, level_d;
  utmi_line_state_t line_q, line_d;
  logic             oen_q, oen_d;

  logic strobe;
  logic stuff_due;
  logic byte_end;
  logic emit;
  logic emit_bit;

  assign strobe    = (state_q != IDLE) && (timer_q == TIMER_LAST);
  assign stuff_due = (ones_q == STUFF_LIMIT);
  // A byte is finished once bit 7 and any stuff bit it triggered are on the line.
  assign byte_end  = ((state_q == SYNC) || (state_q == DATA)) &&
                     (bit_idx_q == 3'd7) && !stuff_due;
  assign tx_ready  = strobe && byte_end && tx_valid && !rst;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    ones_d    = ones_q;
    shift_d   = shift_q;
    level_d   = level_q;
    line_d    = line_q;
    oen_d     = oen_q;
    emit      = 1'b0;
    emit_bit  = 1'b0;

    if (state_q == IDLE) timer_d = '0;
    else                 timer_d = strobe ? '0 : timer_q + TW'(1);

    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d   = SYNC;
          bit_idx_d = '0;
          oen_d     = 1'b1;
          emit      = 1'b1;
          emit_bit  = USB_SYNC_BYTE[0];
        end
      end
      SYNC, DATA: begin
        if (strobe) begin
          if (byte_end) begin
            bit_idx_d = '0;
            if (tx_valid) begin
              state_d  = DATA;
              shift_d  = tx_data;
              emit     = 1'b1;
              emit_bit = tx_data[0];
            end else begin
              state_d = EOP_SE0;
              line_d  = SE0;
            end
          end else if ((state_q == DATA) && stuff_due) begin
            emit     = 1'b1;
            emit_bit = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            emit      = 1'b1;
            emit_bit  = (state_q == SYNC) ? USB_SYNC_BYTE[bit_idx_d] : shift_q[bit_idx_d];
          end
        end
      end
      EOP_SE0: begin
        if (strobe) begin
          if (bit_idx_q == EOP_LAST) begin
            state_d   = EOP_J;
            line_d    = DJ;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      EOP_J: begin
        if (strobe) begin
          state_d   = IDLE;
          oen_d     = 1'b0;
          line_d    = DJ;
          level_d   = DJ;
          ones_d    = '0;
          bit_idx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      level_d = nrzi_next(level_q, emit_bit);
      line_d  = level_d;
      ones_d  = emit_bit ? ones_q + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      ones_q    <= '0;
      shift_q   <= '0;
      level_q   <= DJ;
      line_q    <= DJ;
      oen_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      ones_q    <= ones_d;
      shift_q   <= shift_d;
      level_q   <= level_d;
      line_q    <= line_d;
      oen_q     <= oen_d;
    end
  end

  assign tx_active = (state_q != IDLE);
  assign tx_oen    = oen_q;
  assign dp_tx     = (line_q == DJ);
  assign dn_tx     = (line_q == DK);

endmodule
